// File: rtl/fg_fetch_responder_if.sv
// fg_fetch_responder_if
//   Bundles the foreground-fetch signals seen by the responder:
//   - the pipeline request side: x, y, active, frame_base
//   - the SRAM arbiter read side: rd_en, addr, grant, rd_data
//   - the response side: pixel, skip, ready, drop_count
//
//   Handshake semantics:
//   - Requests are one-shot strobes. fg_pixel_request_active high on a rising
//     clock edge delivers one request, and there is no backpressure.
//   - mem_rd_en/mem_grant form a same-cycle offer. A read counts only when both
//     are high on the same edge, and an ungranted read is abandoned, not retried.
//   - mem_rd_data is valid MEM_READ_LATENCY edges after the granting edge.
//   - fg_pixel_ready is a one-cycle response strobe with no acknowledge.
//
//   Modports:
//   - slave:  the responder.
//   - master: the pipeline/arbiter environment driving it.
interface fg_fetch_responder_if #(
    parameter int PRECISION  = 11,
    parameter int ADDR_WIDTH = 19,
    parameter int PIXEL_SIZE = 16
);
    logic signed [PRECISION:0] fg_pixel_request_x;
    logic signed [PRECISION:0] fg_pixel_request_y;
    logic                      fg_pixel_request_active;
    logic [ADDR_WIDTH-1:0]     frame_base;
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_grant;
    logic [PIXEL_SIZE-1:0]     mem_rd_data;
    logic [PIXEL_SIZE-1:0]     fg_pixel_in;
    logic                      fg_pixel_skip;
    logic                      fg_pixel_ready;
    logic [15:0]               drop_count;

    modport slave (
        input  fg_pixel_request_x, fg_pixel_request_y, fg_pixel_request_active,
        input  frame_base, mem_grant, mem_rd_data,
        output mem_rd_en, mem_addr, fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
        output drop_count
    );

    modport master (
        output fg_pixel_request_x, fg_pixel_request_y, fg_pixel_request_active,
        output frame_base, mem_grant, mem_rd_data,
        input  mem_rd_en, mem_addr, fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
        input  drop_count
    );
endinterface

// File: rtl/fg_fetch_responder.sv
// fg_fetch_responder
//   Turns foreground pixel requests into frame-buffer SRAM reads. Every
//   response (pixel or skip) comes back exactly FOREGROUND_FETCH_CYCLE_DELAY
//   cycles after its request.
//
//   Request edge T:
//   - Bounds check and address computation are registered.
//   Cycle after T:
//   - In-bounds requests drive mem_rd_en/mem_addr.
//   - A missing grant at edge T+1 turns the request into a skip and bumps
//     drop_count.
//   - Read data is captured at edge T+1+MEM_READ_LATENCY, then delayed to meet
//     its tag at edge T+DELAY.
//
//   Ports:
//   - clk:   system clock
//   - rst_n: asynchronous active-low reset
//   - bus:   fg_fetch_responder_if.slave. It carries the request, the SRAM read
//            and the response/drop_count signals.
module fg_fetch_responder #(
    parameter int R_WIDTH                      = 5,
    parameter int G_WIDTH                      = 6,
    parameter int B_WIDTH                      = 5,
    parameter int PRECISION                    = 11,
    parameter int FG_WIDTH                     = 800,
    parameter int FG_HEIGHT                    = 600,
    parameter int ADDR_WIDTH                   = 19,
    parameter int MEM_READ_LATENCY             = 2,
    parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fg_fetch_responder_if.slave  bus
);
    localparam int PIXEL_SIZE = R_WIDTH + G_WIDTH + B_WIDTH;
    // Tag stages after the request register. The output register is the last stage.
    localparam int TAG_DEPTH  = FOREGROUND_FETCH_CYCLE_DELAY - 1;
    // Data stages between the capture edge and the output edge.
    localparam int DATA_DEPTH = FOREGROUND_FETCH_CYCLE_DELAY - 1 - MEM_READ_LATENCY;

    localparam logic [PRECISION:0]  FG_W_C = (PRECISION+1)'(FG_WIDTH);
    localparam logic [PRECISION:0]  FG_H_C = (PRECISION+1)'(FG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] FG_W_A = ADDR_WIDTH'(FG_WIDTH);

    // Request classification (combinational, registered at edge T).
    logic                  x_neg, y_neg, x_big, y_big, req_oob;
    logic [ADDR_WIDTH-1:0] x_a, y_a, addr_c;

    always_comb begin
        x_neg = bus.fg_pixel_request_x[PRECISION];
        y_neg = bus.fg_pixel_request_y[PRECISION];
        // Magnitude compare is only meaningful for non-negative coordinates.
        x_big = !x_neg && ($unsigned(bus.fg_pixel_request_x) >= FG_W_C);
        y_big = !y_neg && ($unsigned(bus.fg_pixel_request_y) >= FG_H_C);
        req_oob = x_neg | y_neg | x_big | y_big;
        x_a = ADDR_WIDTH'($unsigned(bus.fg_pixel_request_x));
        y_a = ADDR_WIDTH'($unsigned(bus.fg_pixel_request_y));
        addr_c = bus.frame_base + y_a * FG_W_A + x_a;
    end

    // Pipeline state.
    logic                  s1_active;
    logic                  s1_oob;
    logic [TAG_DEPTH-1:0]  tag_active;
    logic [TAG_DEPTH-1:0]  tag_skip;
    logic [PIXEL_SIZE-1:0] data_pipe [DATA_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active          <= 1'b0;
            s1_oob             <= 1'b0;
            bus.mem_rd_en      <= 1'b0;
            bus.mem_addr       <= '0;
            tag_active         <= '0;
            tag_skip           <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) data_pipe[i] <= '0;
            bus.fg_pixel_in    <= '0;
            bus.fg_pixel_skip  <= 1'b0;
            bus.fg_pixel_ready <= 1'b0;
            bus.drop_count     <= '0;
        end else begin
            // Edge T: sample the request together with frame_base.
            s1_active     <= bus.fg_pixel_request_active;
            s1_oob        <= req_oob;
            bus.mem_rd_en <= bus.fg_pixel_request_active && !req_oob;
            if (bus.fg_pixel_request_active && !req_oob) bus.mem_addr <= addr_c;

            // Edge T+1: the grant decision is folded into the skip tag.
            tag_active[0] <= s1_active;
            tag_skip[0]   <= s1_oob | (bus.mem_rd_en & !bus.mem_grant);
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_active[i] <= tag_active[i-1];
                tag_skip[i]   <= tag_skip[i-1];
            end

            if (bus.mem_rd_en && !bus.mem_grant && bus.drop_count != 16'hFFFF)
                bus.drop_count <= bus.drop_count + 16'd1;

            // Read data is sampled every cycle. Only slots whose tag is an
            // active non-skip request ever reach fg_pixel_in.
            data_pipe[0] <= bus.mem_rd_data;
            for (int i = 1; i < DATA_DEPTH; i++) data_pipe[i] <= data_pipe[i-1];

            // Edge T+DELAY: response.
            bus.fg_pixel_ready <= tag_active[TAG_DEPTH-1];
            bus.fg_pixel_skip  <= tag_active[TAG_DEPTH-1] & tag_skip[TAG_DEPTH-1];
            bus.fg_pixel_in    <= (tag_active[TAG_DEPTH-1] && !tag_skip[TAG_DEPTH-1])
                                  ? data_pipe[DATA_DEPTH-1] : '0;
        end
    end
endmodule
